// File: rtl/rom_loader.sv
// rom_loader: packs the HPS download byte stream into 32-bit little-endian
// words, queues them in a 2-entry FIFO and writes them to SDRAM via req/ack.
//
// Ports:
//   clk, reset_n        - system clock, synchronous active-low reset
//   ioctl_download      - download active
//   ioctl_wr            - byte strobe (one cycle per byte)
//   ioctl_addr/_data    - byte address / byte value
//   ioctl_wait          - stall request to the HPS (registered)
//   sdram_addr/_data    - 16-bit-word address / 32-bit write data
//   sdram_we, sdram_req - write request, held until sdram_ack
//   sdram_ack           - one-cycle acceptance from the controller
//   busy                - download, assembly or FIFO still active
//   done                - one-cycle pulse once a download has drained
module rom_loader #(
    parameter logic [22:0] BASE_ADDR = 23'h0,
    parameter logic [7:0]  FILL      = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [19:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic        busy,
    output logic        done
);

    typedef struct packed {
        logic [22:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    // Assembler
    logic        dl_q;
    logic        open_q, open_d;
    logic [17:0] word_addr_q, word_addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  lane_valid_q, lane_valid_d;

    // FIFO
    entry_t      fifo_q [2];
    logic        rd_q, wr_q;
    logic [1:0]  count_q, count_d;

    // Write FSM and outputs
    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [22:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wait_q, wait_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        armed_q, armed_d;

    logic [1:0]  lane;
    logic [17:0] waddr;
    logic [3:0]  lane_mask;
    logic        dl_rise, dl_fall;
    logic        accept, pop, room, eff_open, arm;
    logic        push;
    logic [17:0] push_word;
    logic [31:0] push_data;
    logic [31:0] merged, fresh;
    entry_t      push_entry, head, nxt;

    assign lane      = ioctl_addr[1:0];
    assign waddr     = ioctl_addr[19:2];
    assign lane_mask = 4'b0001 << lane;
    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign accept    = ioctl_wr & ioctl_download & ~wait_q;
    assign pop       = (state_q == S_REQ) & sdram_ack;
    assign room      = (count_q != 2'd2) | pop;
    // A new download always starts with the assembler closed.
    assign eff_open  = open_q & ~dl_rise;

    assign head = fifo_q[rd_q];
    assign nxt  = fifo_q[~rd_q];

    always_comb begin
        merged = '0;
        fresh  = '0;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = (lane == k[1:0]) ? ioctl_data
                                                : data_q[8*k +: 8];
            fresh[8*k +: 8]  = (lane == k[1:0]) ? ioctl_data : FILL;
        end
    end

    always_comb begin
        open_d       = open_q;
        word_addr_d  = word_addr_q;
        data_d       = data_q;
        lane_valid_d = lane_valid_q;
        push         = 1'b0;
        push_word    = word_addr_q;
        push_data    = data_q;
        if (dl_rise) begin
            open_d       = 1'b0;
            lane_valid_d = '0;
        end
        if (accept) begin
            if (eff_open && (word_addr_q == waddr)) begin
                if (lane == 2'd3) begin
                    push         = 1'b1;
                    push_data    = merged;
                    open_d       = 1'b0;
                    lane_valid_d = '0;
                end else begin
                    data_d       = merged;
                    lane_valid_d = lane_valid_q | lane_mask;
                end
            end else begin
                // Flush the open word; unwritten lanes already hold FILL.
                if (eff_open) begin
                    push = 1'b1;
                end
                if ((lane == 2'd3) && !eff_open) begin
                    push         = 1'b1;
                    push_word    = waddr;
                    push_data    = fresh;
                    open_d       = 1'b0;
                    lane_valid_d = '0;
                end else begin
                    // A lane-3 byte that arrives with a flush stays open
                    // with lane_valid[3] set and is pushed next cycle.
                    open_d       = 1'b1;
                    word_addr_d  = waddr;
                    data_d       = fresh;
                    lane_valid_d = lane_mask;
                end
            end
        end else if (eff_open && room
                     && (lane_valid_q[3] || !ioctl_download)) begin
            push         = 1'b1;
            open_d       = 1'b0;
            lane_valid_d = '0;
        end
    end

    assign push_entry.addr = BASE_ADDR + {4'b0, push_word, 1'b0};
    assign push_entry.data = push_data;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != 2'd0) begin
                    addr_d  = head.addr;
                    wdata_d = head.data;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (sdram_ack) begin
                    if (count_q == 2'd2) begin
                        addr_d  = nxt.addr;
                        wdata_d = nxt.data;
                    end else if (push) begin
                        addr_d  = push_entry.addr;
                        wdata_d = push_entry.data;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // wait is derived from next-state values so it is high in the very
    // cycle the FIFO holds two entries or a deferred push is queued.
    always_comb begin
        wait_d  = (count_d == 2'd2) | (open_d & lane_valid_d[3]);
        busy_d  = ioctl_download | open_d | (count_d != 2'd0);
        arm     = armed_q | dl_fall;
        done_d  = arm & ~ioctl_download & ~open_q
                & (count_q == 2'd0) & (state_q == S_IDLE);
        armed_d = dl_rise ? 1'b0 : (arm & ~done_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_q         <= 1'b0;
            open_q       <= 1'b0;
            word_addr_q  <= '0;
            data_q       <= '0;
            lane_valid_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            dl_q         <= ioctl_download;
            open_q       <= open_d;
            word_addr_q  <= word_addr_d;
            data_q       <= data_d;
            lane_valid_q <= lane_valid_d;
            if (push) begin
                fifo_q[wr_q] <= push_entry;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            count_q      <= count_d;
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            armed_q      <= armed_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign sdram_addr = addr_q;
    assign sdram_data = wdata_q;
    assign sdram_req  = req_q;
    assign sdram_we   = req_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
